// File: rtl/trimdac_bank.sv
`default_nettype none
// ============================================================================
// Module  : trimdac_bank
// Brief   : Shadow-register bank that rewrites dirty channels of an
//           AD8804-class serial TrimDAC in round-robin order over a CS-framed
//           3-wire link.
// Revision: 1.0 - initial release
// ============================================================================
module trimdac_bank #(
    parameter int                 NUM_CH    = 12,
    parameter int                 ADDR_W    = 4,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = 8'h80,
    parameter int                 CLK_DIV   = 3,
    parameter int                 CSS_CYC   = 2,
    parameter int                 CSH_CYC   = 4,
    parameter int                 CSW_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              refresh,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_err,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] done_ch,
    output logic              dac_sclk,
    output logic              dac_sdi,
    output logic              dac_cs_n
);

    localparam int              c_FRAME_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W:0] c_NUM_CH  = (ADDR_W+1)'(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    logic [DATA_W-1:0]    r_shadow [NUM_CH];
    logic [NUM_CH-1:0]    r_dirty;
    logic [NUM_CH-1:0]    w_dirty_nxt;
    logic [ADDR_W-1:0]    r_rr;
    logic [ADDR_W-1:0]    r_ch;
    logic [ADDR_W-1:0]    w_pick_ch;
    logic [ADDR_W:0]      w_idx;
    logic                 w_pick_found;
    logic                 w_pick;
    logic                 w_wr_ok;
    logic                 w_busy_nxt;
    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [7:0]           r_bit;
    logic [c_FRAME_W-1:0] r_shift;

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_NUM_CH);
    assign w_pick  = (r_state == ST_IDLE) && w_pick_found;
    assign rd_data = ({1'b0, rd_addr} < c_NUM_CH) ? r_shadow[rd_addr] : '0;

    // Scan from farthest to nearest so the first dirty channel after r_rr wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_ch    = '0;
        w_idx        = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = {1'b0, r_rr} + (ADDR_W+1)'(i);
            if (w_idx >= c_NUM_CH) begin
                w_idx = w_idx - c_NUM_CH;
            end
            if (r_dirty[w_idx[ADDR_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_ch    = w_idx[ADDR_W-1:0];
            end
        end
    end

    // A set from refresh or a host write overrides the clear from a pick.
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_pick) begin
            w_dirty_nxt[w_pick_ch] = 1'b0;
        end
        if (refresh) begin
            w_dirty_nxt = '1;
        end
        if (w_wr_ok) begin
            w_dirty_nxt[wr_addr] = 1'b1;
        end
    end

    assign w_busy_nxt = (|w_dirty_nxt) ||
                        !(((r_state == ST_IDLE) && !w_pick_found) ||
                          ((r_state == ST_GAP) && (r_cnt == 8'd0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= RESET_VAL;
            end
            r_dirty <= '1;
            wr_err  <= 1'b0;
            busy    <= 1'b1;
        end else begin
            r_dirty <= w_dirty_nxt;
            wr_err  <= wr_en && !w_wr_ok;
            busy    <= w_busy_nxt;
            if (w_wr_ok) begin
                r_shadow[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_ch     <= '0;
            r_rr     <= ADDR_W'(NUM_CH - 1);
            dac_cs_n <= 1'b1;
            dac_sclk <= 1'b0;
            dac_sdi  <= 1'b0;
            done     <= 1'b0;
            done_ch  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_shift  <= {w_pick_ch, r_shadow[w_pick_ch]};
                        dac_sdi  <= w_pick_ch[ADDR_W-1];
                        r_ch     <= w_pick_ch;
                        r_rr     <= w_pick_ch;
                        r_cnt    <= 8'(CSS_CYC - 1);
                        r_bit    <= '0;
                        dac_cs_n <= 1'b0;
                        dac_sclk <= 1'b0;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_cnt   <= 8'(CLK_DIV - 1);
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (!dac_sclk) begin
                        dac_sclk <= 1'b1;
                        r_cnt    <= 8'(CLK_DIV - 1);
                    end else begin
                        dac_sclk <= 1'b0;
                        if (r_bit == 8'(c_FRAME_W - 1)) begin
                            r_cnt   <= 8'(CSH_CYC - 1);
                            r_state <= ST_HOLD;
                        end else begin
                            // Rotate so the next bit sits at the MSB; data moves only at low-phase start.
                            r_shift <= {r_shift[c_FRAME_W-2:0], r_shift[c_FRAME_W-1]};
                            dac_sdi <= r_shift[c_FRAME_W-2];
                            r_bit   <= r_bit + 8'd1;
                            r_cnt   <= 8'(CLK_DIV - 1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        dac_cs_n <= 1'b1;
                        dac_sdi  <= 1'b0;
                        done     <= 1'b1;
                        done_ch  <= r_ch;
                        r_cnt    <= 8'(CSW_CYC - 1);
                        r_state  <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trimdac_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_trimdac_bank
// Brief   : Self-checking bench for trimdac_bank: a pin-level frame monitor
//           compares every serial frame against a queue of expected frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trimdac_bank;

    localparam int FRAME_W  = 12;
    localparam int CS_LOW   = 78;  // setup 2 + shift 72 + hold 4

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       refresh = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       wr_err, busy, done, dac_sclk, dac_sdi, dac_cs_n;
    logic [3:0] done_ch;

    trimdac_bank dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .refresh(refresh), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_err(wr_err), .busy(busy), .done(done),
        .done_ch(done_ch), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
        .dac_cs_n(dac_cs_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [FRAME_W-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pin monitor: samples on the falling clk edge, rebuilds each frame.
    logic               prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, first_low = 1'b0;
    logic               tim_ok = 1'b1;
    logic [FRAME_W-1:0] shreg = '0, exp_frame;
    int                 mon_bits = 0, mon_frames = 0, run = 0, cs_low = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (done && !(prev_cs == 1'b0 && dac_cs_n == 1'b1)) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 with cs_n=%0b, expected 0", dac_cs_n);
            end
            if (prev_cs && !dac_cs_n) begin
                in_frame  = 1'b1;
                mon_bits  = 0;
                shreg     = '0;
                cs_low    = 0;
                run       = 0;
                tim_ok    = 1'b1;
                first_low = 1'b1;
            end
            if (in_frame) begin
                if (!dac_cs_n) begin
                    cs_low++;
                    if (dac_sclk && !prev_sclk) begin
                        if (run != (first_low ? 5 : 3)) tim_ok = 1'b0;
                        first_low = 1'b0;
                        shreg = {shreg[FRAME_W-2:0], dac_sdi};
                        mon_bits++;
                        run = 1;
                    end else if (!dac_sclk && prev_sclk) begin
                        if (run != 3) tim_ok = 1'b0;
                        run = 1;
                    end else begin
                        run++;
                    end
                end else begin
                    in_frame = 1'b0;
                    if (run != 4) tim_ok = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %03h, expected no frame", shreg);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        check("frame_data", int'(shreg), int'(exp_frame));
                    end
                    check("frame_bits", mon_bits, FRAME_W);
                    check("frame_sclk_timing", int'(tim_ok), 1);
                    check("frame_cs_low_cycles", cs_low, CS_LOW);
                    check("done_pulse", int'(done), 1);
                    check("done_ch", int'(done_ch), int'(shreg[11:8]));
                    mon_frames++;
                end
            end
            prev_cs   = dac_cs_n;
            prev_sclk = dac_sclk;
        end
    end

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while (!(busy == 1'b0 && dac_cs_n == 1'b1) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle_reached"}, int'(busy == 1'b0 && dac_cs_n == 1'b1), 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       err;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int k;
        int quiet;
        vecs[0] = '{addr: 4'd5,  data: 8'hA7, err: 1'b0, rd: 8'hA7};
        vecs[1] = '{addr: 4'd12, data: 8'h5A, err: 1'b1, rd: 8'h00};
        vecs[2] = '{addr: 4'd15, data: 8'hC3, err: 1'b1, rd: 8'h00};
        vecs[3] = '{addr: 4'd0,  data: 8'h00, err: 1'b0, rd: 8'h00};
        vecs[4] = '{addr: 4'd11, data: 8'hFF, err: 1'b0, rd: 8'hFF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(dac_cs_n), 1);
        check("rst_sclk", int'(dac_sclk), 0);
        check("rst_sdi", int'(dac_sdi), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_err", int'(wr_err), 0);
        check("rst_done_ch", int'(done_ch), 0);
        rd_addr = 4'd0;
        #1 check("rst_rd_data", int'(rd_data), 8'h80);

        for (int ch = 0; ch < 12; ch++) exp_q.push_back({ch[3:0], 8'h80});
        @(negedge clk);
        rst_n = 1'b1;

        // While channel 11 (rr=11) is on the wire, post writes to 3, 9, 1;
        // after that frame the round-robin resumes from 11 -> 1, 3, 9.
        k = 0;
        while (!(mon_frames == 11 && dac_cs_n == 1'b0) && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check("reach_ch11_frame", int'(mon_frames == 11 && dac_cs_n == 1'b0), 1);
        @(negedge clk); wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h33;
        @(negedge clk); wr_addr = 4'd9; wr_data = 8'h99;
        @(negedge clk); wr_addr = 4'd1; wr_data = 8'h1E;
        @(negedge clk); wr_en = 1'b0;
        exp_q.push_back({4'd1, 8'h1E});
        exp_q.push_back({4'd3, 8'h33});
        exp_q.push_back({4'd9, 8'h99});
        wait_idle("startup", 2000);

        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dac_cs_n && !busy) quiet++;
        end
        check("idle_quiet_cycles", quiet, 20);

        // Single writes from idle, valid and out of range
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = vecs[v].addr;
            wr_data = vecs[v].data;
            if (!vecs[v].err) exp_q.push_back({vecs[v].addr, vecs[v].data});
            @(negedge clk);
            wr_en = 1'b0;
            check("wr_err_pulse", int'(wr_err), int'(vecs[v].err));
            check("cs_n_write_plus1", int'(dac_cs_n), 1);
            @(negedge clk);
            check("cs_n_write_plus2", int'(dac_cs_n), vecs[v].err ? 1 : 0);
            check("wr_err_one_cycle", int'(wr_err), 0);
            rd_addr = vecs[v].addr;
            #1 check("rd_data", int'(rd_data), int'(vecs[v].rd));
            wait_idle("single_write", 300);
            if (!vecs[v].err) check("done_ch_held", int'(done_ch), int'(vecs[v].addr));
        end

        // Rewrite a channel while its frame is on the wire
        write(4'd4, 8'h22);
        exp_q.push_back({4'd4, 8'h22});
        k = 0;
        while (dac_cs_n && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("rewrite_frame_start", int'(dac_cs_n), 0);
        repeat (20) @(negedge clk);
        write(4'd4, 8'h11);
        exp_q.push_back({4'd4, 8'h11});
        wait_idle("rewrite", 400);
        rd_addr = 4'd4;
        #1 check("rewrite_rd_data", int'(rd_data), 8'h11);

        // Reset mid-frame while bit 6 is being shifted
        write(4'd7, 8'h3C);
        k = 0;
        while (!(in_frame && mon_bits == 6) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_bit6", mon_bits, 6);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", int'(dac_cs_n), 1);
        check("async_rst_sclk", int'(dac_sclk), 0);
        check("async_rst_done", int'(done), 0);
        for (int ch = 0; ch < 12; ch++) exp_q.push_back({ch[3:0], 8'h80});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_addr = 4'd7;
        #1 check("post_rst_rd_ch7", int'(rd_data), 8'h80);
        wait_idle("post_reset", 2000);
        rd_addr = 4'd11;
        #1 check("post_rst_rd_ch11", int'(rd_data), 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
